// File: rtl/reg_ce_rr_arbiter_pkg.sv
// Shared constants and round-robin helper functions for reg_ce_rr_arbiter.
package reg_ce_rr_arbiter_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefN     = 4;
  localparam int unsigned MaxN     = 16;
  localparam int unsigned MaxIdw   = 4;

  // One-hot grant for the first set request scanning ptr, ptr+1, ... modulo n.
  function automatic logic [MaxN-1:0] rr_pick(input logic [MaxN-1:0]   req,
                                               input logic [MaxIdw-1:0] ptr,
                                               input int unsigned       n);
    logic [MaxN-1:0]   gnt;
    logic [MaxIdw-1:0] idx;
    logic              found;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxN; i++) begin
      if (i < n && !found) begin
        idx = MaxIdw'((32'(ptr) + i) % n);
        if (req[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

  function automatic logic [MaxIdw-1:0] onehot_to_idx(input logic [MaxN-1:0] oh);
    logic [MaxIdw-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MaxN; i++) begin
      if (oh[i]) idx |= MaxIdw'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ce_register.sv
// Clock-enabled register with synchronous clear.
module ce_register
  import reg_ce_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I,
  input  logic             CE,
  output logic [WIDTH-1:0] O
);

  logic [WIDTH-1:0] value_d, value_q;

  always_comb begin
    value_d = value_q;
    if (CE) value_d = I;
  end

  always_ff @(posedge CLK) begin
    if (RESET) value_q <= '0;
    else       value_q <= value_d;
  end

  assign O = value_q;

endmodule

// File: rtl/reg_ce_rr_arbiter.sv
// Round-robin arbiter sharing one clock-enabled register among N write requesters.
module reg_ce_rr_arbiter
  import reg_ce_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned N     = DefN,
  localparam int unsigned IDW  = $clog2(N)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] data,
  input  logic               hold,
  output logic [N-1:0]       gnt,
  output logic [WIDTH-1:0]   O,
  output logic [IDW-1:0]     owner,
  output logic               valid
);

  logic [IDW-1:0]   owner_d, owner_q;
  logic [IDW-1:0]   ptr_d, ptr_q;
  logic             valid_d, valid_q;
  logic [IDW-1:0]   gnt_idx;
  logic [WIDTH-1:0] sel_data;
  logic             ce;

  always_comb begin
    gnt = '0;
    if (!RESET && !hold && (req != '0)) begin
      gnt = N'(rr_pick(MaxN'(req), MaxIdw'(ptr_q), N));
    end
    ce      = |gnt;
    gnt_idx = IDW'(onehot_to_idx(MaxN'(gnt)));

    sel_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt[i]) sel_data |= data[i*WIDTH +: WIDTH];
    end

    owner_d = owner_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (ce) begin
      owner_d = gnt_idx;
      valid_d = 1'b1;
      // Wrap at N, not 2^IDW, so non-power-of-two N never points past the last requester.
      ptr_d   = (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      owner_q <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      owner_q <= owner_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  ce_register #(
    .WIDTH (WIDTH)
  ) u_value (
    .CLK   (CLK),
    .RESET (RESET),
    .I     (sel_data),
    .CE    (ce),
    .O     (O)
  );

  assign owner = owner_q;
  assign valid = valid_q;

  always_ff @(posedge CLK) begin
    assert ($onehot0(gnt));
  end

endmodule

// File: tb/tb_reg_ce_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_reg_ce_rr_arbiter;

  localparam int W   = 16;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           CLK = 1'b0;
  logic           RESET = 1'b1;
  logic           hold = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data = '0;
  logic [N-1:0]   gnt;
  logic [W-1:0]   O;
  logic [IDW-1:0] owner;
  logic           valid;

  logic [W-1:0] d [N];
  int  m_value, m_owner, m_ptr;
  bit  m_valid;
  int  n_vec, n_err;
  logic [N-1:0] last_gnt;

  always #5 CLK = ~CLK;

  reg_ce_rr_arbiter #(.WIDTH(W), .N(N)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .req   (req),
    .data  (data),
    .hold  (hold),
    .gnt   (gnt),
    .O     (O),
    .owner (owner),
    .valid (valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Winner by the rotating-priority rule, or -1 when nobody may be granted.
  function automatic int model_pick(input bit rst, input bit h, input logic [N-1:0] r);
    if (rst || h || r == '0) return -1;
    for (int k = 0; k < N; k++) begin
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic cyc(input bit rst, input logic [N-1:0] r, input bit h);
    int g;
    logic [N-1:0] eg;
    @(negedge CLK);
    RESET = rst;
    req   = r;
    hold  = h;
    for (int i = 0; i < N; i++) data[i*W +: W] = d[i];
    #1;
    g  = model_pick(rst, h, r);
    eg = (g < 0) ? '0 : N'(1 << g);
    last_gnt = gnt;
    chk("gnt",   32'(gnt),   32'(eg));
    chk("O",     32'(O),     32'(m_value));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("valid", 32'(valid), 32'(m_valid));
    @(posedge CLK);
    if (rst) begin
      m_value = 0; m_owner = 0; m_valid = 0; m_ptr = 0;
    end else if (g >= 0) begin
      m_value = int'(d[g]); m_owner = g; m_valid = 1; m_ptr = (g + 1) % N;
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_value = 0; m_owner = 0; m_valid = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) d[i] = '0;

    // Reset then idle
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b1, 4'b1111, 1'b0);
    chk("t1_gnt_in_reset", 32'(last_gnt), 32'h0);
    repeat (10) cyc(1'b0, 4'b0000, 1'b0);
    chk("t1_O_idle", 32'(O), 32'h0);

    // Single writer
    d[2] = 16'hBEEF;
    cyc(1'b0, 4'b0100, 1'b0);
    chk("t2_gnt", 32'(last_gnt), 32'b0100);
    cyc(1'b0, 4'b0000, 1'b0);
    chk("t2_O", 32'(O), 32'hBEEF);
    chk("t2_owner", 32'(owner), 32'd2);

    // Wrap and skip from ptr=3
    d[0] = 16'h00A0; d[1] = 16'h00A1; d[3] = 16'h00A3;
    cyc(1'b0, 4'b0011, 1'b0);
    chk("t4_first", 32'(last_gnt), 32'b0001);
    cyc(1'b0, 4'b0011, 1'b0);
    cyc(1'b0, 4'b0011, 1'b0);
    chk("t4_again", 32'(last_gnt), 32'b0001);
    cyc(1'b0, 4'b1000, 1'b0);
    cyc(1'b0, 4'b1001, 1'b0);
    chk("t4_wrap", 32'(last_gnt), 32'b0001);

    // Full contention from ptr=0, with a hold after the grant to 1
    cyc(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < N; i++) d[i] = W'(16'h1000 + i);
    cyc(1'b0, 4'b1111, 1'b0);
    cyc(1'b0, 4'b1111, 1'b0);
    repeat (3) cyc(1'b0, 4'b1111, 1'b1);
    chk("t5_O_frozen", 32'(O), 32'h1001);
    cyc(1'b0, 4'b1111, 1'b0);
    chk("t5_resume", 32'(last_gnt), 32'b0100);
    repeat (7) cyc(1'b0, 4'b1111, 1'b0);

    // Reset mid-contention
    cyc(1'b1, 4'b1010, 1'b0);
    chk("t6_gnt_in_reset", 32'(last_gnt), 32'h0);
    cyc(1'b0, 4'b1010, 1'b0);
    chk("t6_restart", 32'(last_gnt), 32'b0010);

    // Random traffic
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) d[i] = W'($urandom);
      cyc($urandom_range(0, 39) == 0, N'($urandom), $urandom_range(0, 5) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
